// File: rtl/cv32e40p_pkg.sv
// Shared constants and types for the APU write-back arbiter slice.
package cv32e40p_pkg;

  // Default number of buffered APU results.
  localparam int APU_WB_DEPTH  = 2;
  // Register-file write address width; bit 5 selects the FP register file.
  localparam int APU_WB_ADDR_W = 6;

  // One buffered APU result waiting for a free write-port cycle.
  typedef struct packed {
    logic [APU_WB_ADDR_W-1:0] waddr;
    logic [31:0]              wdata;
  } apu_wb_entry_t;

endpackage

// File: rtl/cv32e40p_apu_wb_fifo.sv
// Small circular buffer holding APU results that lost the write port.
// Full/empty come from the occupancy count; per-entry valid bits and
// addresses are exported so the top can do dependency lookups.
module cv32e40p_apu_wb_fifo
  import cv32e40p_pkg::*;
#(
  parameter int  DEPTH  = APU_WB_DEPTH,
  parameter int  ADDR_W = APU_WB_ADDR_W,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_n,
  input  logic                           push,
  input  apu_wb_entry_t                  push_entry,
  input  logic                           pop,
  output apu_wb_entry_t                  head,
  output logic [CNT_W-1:0]               count,
  output logic [DEPTH-1:0]               head_sel,
  output logic [DEPTH-1:0]               entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]   entry_addr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  apu_wb_entry_t    mem [DEPTH];

  // Pointers wrap modulo DEPTH, so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Control state: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (pop) begin
        rd_ptr              <= ptr_inc(rd_ptr);
        entry_valid[rd_ptr] <= 1'b0;
      end
      // NOTE: push is written after pop so that, when full with both active
      // (rd_ptr == wr_ptr), the last non-blocking assignment keeps the slot valid.
      if (push) begin
        wr_ptr              <= ptr_inc(wr_ptr);
        entry_valid[wr_ptr] <= 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage.
  // NOTE: the data array is deliberately not reset; entry_valid alone says
  // which slots mean anything, which keeps the storage plain flops/RAM.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

  // Expose the head position and every stored address for lookups.
  always_comb begin
    head_sel   = '0;
    entry_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      head_sel[i]   = (rd_ptr == PTR_W'(i));
      entry_addr[i] = ADDR_W'(mem[i].waddr);
    end
  end

endmodule

// File: rtl/cv32e40p_apu_wb_arbiter.sv
// Shares one register-file write port between the core pipeline and the APU.
// The core always wins; APU results bypass when idle or queue in a FIFO.
module cv32e40p_apu_wb_arbiter
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH  = APU_WB_DEPTH,
  parameter int ADDR_W = APU_WB_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_waddr_i,
  input  logic [31:0]       core_wdata_i,
  input  logic              apu_valid_i,
  input  logic [ADDR_W-1:0] apu_waddr_i,
  input  logic [31:0]       apu_result_i,
  output logic              apu_stall_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [31:0]       rf_wdata_o,
  input  logic [ADDR_W-1:0] chk_addr_i,
  output logic              chk_hit_o,
  output logic              overflow_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                         fifo_push;
  logic                         fifo_pop;
  logic                         fifo_empty;
  logic                         fifo_full;
  logic                         bypass;
  logic                         apu_pending;
  logic                         drop;
  logic [CNT_W-1:0]             fifo_count;
  apu_wb_entry_t                push_entry;
  apu_wb_entry_t                head;
  logic [DEPTH-1:0]             head_sel;
  logic [DEPTH-1:0]             entry_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;

  assign fifo_empty  = (fifo_count == '0);
  assign fifo_full   = (fifo_count == CNT_W'(DEPTH));
  // Queued results always drain before any new result may bypass.
  assign fifo_pop    = !core_we_i && !fifo_empty;
  assign bypass      = !core_we_i && fifo_empty && apu_valid_i;
  assign apu_pending = apu_valid_i && !bypass;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign fifo_push   = apu_pending && (!fifo_full || fifo_pop);
  assign drop        = apu_pending && fifo_full && !fifo_pop;

  assign push_entry.waddr = APU_WB_ADDR_W'(apu_waddr_i);
  assign push_entry.wdata = apu_result_i;

  // One slot of headroom absorbs a result already in flight when stall rises.
  assign apu_stall_o = (fifo_count >= CNT_W'(DEPTH - 1));

  cv32e40p_apu_wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .push        (fifo_push),
    .push_entry  (push_entry),
    .pop         (fifo_pop),
    .head        (head),
    .count       (fifo_count),
    .head_sel    (head_sel),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // Write-port mux: core, then FIFO head, then zero-latency APU bypass.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (core_we_i) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = core_waddr_i;
      rf_wdata_o = core_wdata_i;
    end else if (fifo_pop) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = ADDR_W'(head.waddr);
      rf_wdata_o = head.wdata;
    end else if (bypass) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = apu_waddr_i;
      rf_wdata_o = apu_result_i;
    end
  end

  // Dependency lookup over live entries, minus the one retiring this cycle,
  // plus the result being enqueued right now.
  always_comb begin
    chk_hit_o = fifo_push && (apu_waddr_i == chk_addr_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && !(fifo_pop && head_sel[i]) &&
          (entry_addr[i] == chk_addr_i)) begin
        chk_hit_o = 1'b1;
      end
    end
  end

  // Sticky drop flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n) overflow_o <= 1'b0;
    else if (drop) overflow_o <= 1'b1;
  end

endmodule

// File: tb/tb_cv32e40p_apu_wb_arbiter.sv
// Directed, table-driven bench for the APU write-back arbiter (DEPTH=2).
// Each table row is one clock cycle: inputs applied, then the outputs of
// that same cycle compared before the next rising edge.
module tb_cv32e40p_apu_wb_arbiter;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 6;
  localparam int NVEC   = 22;

  logic              clk_i = 1'b0;
  logic              rst_n;
  logic              core_we_i;
  logic [ADDR_W-1:0] core_waddr_i;
  logic [31:0]       core_wdata_i;
  logic              apu_valid_i;
  logic [ADDR_W-1:0] apu_waddr_i;
  logic [31:0]       apu_result_i;
  logic              apu_stall_o;
  logic              rf_we_o;
  logic [ADDR_W-1:0] rf_waddr_o;
  logic [31:0]       rf_wdata_o;
  logic [ADDR_W-1:0] chk_addr_i;
  logic              chk_hit_o;
  logic              overflow_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  cv32e40p_apu_wb_arbiter #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .core_we_i    (core_we_i),
    .core_waddr_i (core_waddr_i),
    .core_wdata_i (core_wdata_i),
    .apu_valid_i  (apu_valid_i),
    .apu_waddr_i  (apu_waddr_i),
    .apu_result_i (apu_result_i),
    .apu_stall_o  (apu_stall_o),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .chk_addr_i   (chk_addr_i),
    .chk_hit_o    (chk_hit_o),
    .overflow_o   (overflow_o)
  );

  typedef struct {
    logic        rst_n;
    logic        core_we;
    logic [5:0]  core_waddr;
    logic [31:0] core_wdata;
    logic        apu_valid;
    logic [5:0]  apu_waddr;
    logic [31:0] apu_result;
    logic [5:0]  chk_addr;
    logic        exp_we;
    logic [5:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_stall;
    logic        exp_hit;
    logic        exp_ovf;
    int          exp_count;   // registered occupancy during this cycle
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input int row,
                       input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s row=%0d actual=0x%0h expected=0x%0h", name, row, actual, expected);
    end
  endtask

  task automatic drive_idle();
    core_we_i    = 1'b0;
    core_waddr_i = '0;
    core_wdata_i = '0;
    apu_valid_i  = 1'b0;
    apu_waddr_i  = '0;
    apu_result_i = '0;
    chk_addr_i   = '0;
  endtask

  initial begin
    //            rst we  caddr  cdata          av  aaddr  adata          chk    | we  waddr  wdata          st hit ovf cnt
    // Idle bypass, then core/APU collision with the APU result queued.
    vecs[0]  = '{1, 0, 6'h00, 32'h0,        1, 6'h23, 32'hDEADBEEF, 6'h23, 1, 6'h23, 32'hDEADBEEF, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 6'h05, 32'h11,       1, 6'h23, 32'hA5A5A5A5, 6'h23, 1, 6'h05, 32'h11,       0, 1, 0, 0};
    vecs[2]  = '{1, 0, 6'h00, 32'h0,        0, 6'h00, 32'h0,        6'h23, 1, 6'h23, 32'hA5A5A5A5, 1, 0, 0, 1};
    // Fill under a busy core, drop a third result, then push/pop at full.
    vecs[3]  = '{1, 1, 6'h01, 32'h100,      1, 6'h21, 32'h2100,     6'h00, 1, 6'h01, 32'h100,      0, 0, 0, 0};
    vecs[4]  = '{1, 1, 6'h02, 32'h200,      1, 6'h22, 32'h2200,     6'h21, 1, 6'h02, 32'h200,      1, 1, 0, 1};
    vecs[5]  = '{1, 1, 6'h03, 32'h300,      1, 6'h25, 32'h2500,     6'h25, 1, 6'h03, 32'h300,      1, 0, 0, 2};
    vecs[6]  = '{1, 1, 6'h04, 32'h400,      0, 6'h00, 32'h0,        6'h22, 1, 6'h04, 32'h400,      1, 1, 1, 2};
    vecs[7]  = '{1, 0, 6'h00, 32'h0,        1, 6'h24, 32'h2400,     6'h21, 1, 6'h21, 32'h2100,     1, 0, 1, 2};
    vecs[8]  = '{1, 0, 6'h00, 32'h0,        0, 6'h00, 32'h0,        6'h24, 1, 6'h22, 32'h2200,     1, 1, 1, 2};
    vecs[9]  = '{1, 0, 6'h00, 32'h0,        0, 6'h00, 32'h0,        6'h05, 1, 6'h24, 32'h2400,     1, 0, 1, 1};
    vecs[10] = '{1, 0, 6'h00, 32'h0,        0, 6'h00, 32'h0,        6'h24, 0, 6'h00, 32'h0,        0, 0, 1, 0};
    // Refill, then reset mid-operation while an APU result arrives.
    vecs[11] = '{1, 1, 6'h06, 32'h600,      1, 6'h21, 32'h1111,     6'h00, 1, 6'h06, 32'h600,      0, 0, 1, 0};
    vecs[12] = '{1, 1, 6'h07, 32'h700,      1, 6'h22, 32'h2222,     6'h22, 1, 6'h07, 32'h700,      1, 1, 1, 1};
    vecs[13] = '{0, 0, 6'h00, 32'h0,        1, 6'h26, 32'h6666,     6'h21, 1, 6'h21, 32'h1111,     1, 0, 1, 2};
    vecs[14] = '{1, 0, 6'h00, 32'h0,        0, 6'h00, 32'h0,        6'h21, 0, 6'h00, 32'h0,        0, 0, 0, 0};
    vecs[15] = '{1, 0, 6'h00, 32'h0,        0, 6'h00, 32'h0,        6'h26, 0, 6'h00, 32'h0,        0, 0, 0, 0};
    // Clean push/pop at full without a prior overflow, then drain.
    vecs[16] = '{1, 1, 6'h08, 32'h800,      1, 6'h21, 32'hA1,       6'h00, 1, 6'h08, 32'h800,      0, 0, 0, 0};
    vecs[17] = '{1, 1, 6'h09, 32'h900,      1, 6'h22, 32'hA2,       6'h00, 1, 6'h09, 32'h900,      1, 0, 0, 1};
    vecs[18] = '{1, 0, 6'h00, 32'h0,        1, 6'h24, 32'hA4,       6'h24, 1, 6'h21, 32'hA1,       1, 1, 0, 2};
    vecs[19] = '{1, 0, 6'h00, 32'h0,        0, 6'h00, 32'h0,        6'h22, 1, 6'h22, 32'hA2,       1, 0, 0, 2};
    vecs[20] = '{1, 0, 6'h00, 32'h0,        0, 6'h00, 32'h0,        6'h24, 1, 6'h24, 32'hA4,       1, 0, 0, 1};
    vecs[21] = '{1, 0, 6'h00, 32'h0,        0, 6'h00, 32'h0,        6'h24, 0, 6'h00, 32'h0,        0, 0, 0, 0};

    // Hand sequence: hold reset over two edges, then check the reset state.
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;
    #2;
    check("reset_stall", -1, 32'(apu_stall_o), 32'h0);
    check("reset_ovf",   -1, 32'(overflow_o),  32'h0);
    check("reset_hit",   -1, 32'(chk_hit_o),   32'h0);
    check("reset_we",    -1, 32'(rf_we_o),     32'h0);
    check("reset_count", -1, 32'(dut.fifo_count), 32'h0);

    // Table: one row per cycle, outputs compared mid-cycle.
    for (int i = 0; i < NVEC; i++) begin
      rst_n        = vecs[i].rst_n;
      core_we_i    = vecs[i].core_we;
      core_waddr_i = vecs[i].core_waddr;
      core_wdata_i = vecs[i].core_wdata;
      apu_valid_i  = vecs[i].apu_valid;
      apu_waddr_i  = vecs[i].apu_waddr;
      apu_result_i = vecs[i].apu_result;
      chk_addr_i   = vecs[i].chk_addr;
      #2;
      check("rf_we",    i, 32'(rf_we_o),         32'(vecs[i].exp_we));
      check("rf_waddr", i, 32'(rf_waddr_o),      32'(vecs[i].exp_waddr));
      check("rf_wdata", i, rf_wdata_o,           vecs[i].exp_wdata);
      check("stall",    i, 32'(apu_stall_o),     32'(vecs[i].exp_stall));
      check("chk_hit",  i, 32'(chk_hit_o),       32'(vecs[i].exp_hit));
      check("overflow", i, 32'(overflow_o),      32'(vecs[i].exp_ovf));
      check("count",    i, 32'(dut.fifo_count),  32'(vecs[i].exp_count));
      @(posedge clk_i);
      #1;
    end

    // Hand sequence: after reset the lookup misses every address.
    drive_idle();
    for (int a = 0; a < 64; a += 9) begin
      chk_addr_i = 6'(a);
      #1;
      check("post_hit_sweep", a, 32'(chk_hit_o), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
